pipeline_sched: RTL

Two-requester round-robin scheduler that shares one fixed-latency, non-stallable arithmetic pipeline (the `pipeline` unit with operands A1/A2/B1/B2 and result C). It accepts operand sets through valid/ready handshakes, registers them onto the pipeline inputs, and tracks each issue with a requester tag. When the result emerges, it is routed back to the requester that issued it. It sits between the operand sources and the `pipeline` instance, and treats the pipeline function as opaque.

---
 rtl/pipeline_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipeline_sched.sv
// Round-robin issue of two requesters into a fixed-latency pipeline; result pulse LAT+1 edges after accept.
// Backpressure only on accept (ready); results are never stalled and return in issue order.
module pipeline_sched #(
  parameter int W   = 32,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sched_en,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a1,
  input  logic [W-1:0] req0_a2,
  input  logic [W-1:0] req0_b1,
  input  logic [W-1:0] req0_b2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a1,
  input  logic [W-1:0] req1_a2,
  input  logic [W-1:0] req1_b1,
  input  logic [W-1:0] req1_b2,
  output logic [W-1:0] pipe_a1,
  output logic [W-1:0] pipe_a2,
  output logic [W-1:0] pipe_b1,
  output logic [W-1:0] pipe_b2,
  input  logic [W-1:0] pipe_c,
  output logic         res0_valid,
  output logic         res1_valid,
  output logic [W-1:0] res_data,
  output logic         busy
);

  logic         r_last;
  logic         r_issue_v;
  logic         r_issue_id;
  logic [W-1:0] r_pipe_a1, r_pipe_a2, r_pipe_b1, r_pipe_b2;
  logic [LAT-1:0] r_tag_v;
  logic [LAT-1:0] r_tag_id;
  logic         r_res0_v, r_res1_v;
  logic [W-1:0] r_res_data;

  logic w_grant;
  logic w_acc0, w_acc1, w_accept;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = ~r_last;
    else if (req1_valid)          w_grant = 1'b1;
  end

  assign w_acc0   = rst_n & sched_en & req0_valid & ~w_grant;
  assign w_acc1   = rst_n & sched_en & req1_valid &  w_grant;
  assign w_accept = w_acc0 | w_acc1;

  assign req0_ready = w_acc0;
  assign req1_ready = w_acc1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_issue_v  <= 1'b0;
      r_issue_id <= 1'b0;
      r_pipe_a1  <= '0;
      r_pipe_a2  <= '0;
      r_pipe_b1  <= '0;
      r_pipe_b2  <= '0;
    end else if (w_accept) begin
      r_last     <= w_grant;
      r_issue_v  <= 1'b1;
      r_issue_id <= w_grant;
      r_pipe_a1  <= w_grant ? req1_a1 : req0_a1;
      r_pipe_a2  <= w_grant ? req1_a2 : req0_a2;
      r_pipe_b1  <= w_grant ? req1_b1 : req0_b1;
      r_pipe_b2  <= w_grant ? req1_b2 : req0_b2;
    end else begin
      r_issue_v  <= 1'b0;
    end
  end

  // Tag line mirrors the pipeline depth so the last stage lines up with pipe_c.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= r_issue_v;
      r_tag_id[0] <= r_issue_id;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res0_v   <= 1'b0;
      r_res1_v   <= 1'b0;
      r_res_data <= '0;
    end else if (r_tag_v[LAT-1]) begin
      r_res0_v   <= ~r_tag_id[LAT-1];
      r_res1_v   <=  r_tag_id[LAT-1];
      r_res_data <= pipe_c;
    end else begin
      r_res0_v   <= 1'b0;
      r_res1_v   <= 1'b0;
    end
  end

  assign pipe_a1    = r_pipe_a1;
  assign pipe_a2    = r_pipe_a2;
  assign pipe_b1    = r_pipe_b1;
  assign pipe_b2    = r_pipe_b2;
  assign res0_valid = r_res0_v;
  assign res1_valid = r_res1_v;
  assign res_data   = r_res_data;
  assign busy       = r_issue_v | (|r_tag_v) | r_res0_v | r_res1_v;

endmodule
